sm83_alu: RTL and testbench

// - 8-bit SM83 (Game Boy) ALU: combinational datapath for the CPU's ALU ops, acc/flag ops, CB rotates/shifts, bit ops and inc/dec.
// - Adds a one-bit carry latch for the two-byte 16-bit add sequence (low byte, then high byte).
// - Sits between the register-file read ports and the write-back/flag mux of the CPU.

---
 rtl/sm83_alu.sv | 141 ++++++++++++++
 tb/tb_sm83_alu.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sm83_alu.sv
// SM83 (Game Boy) 8-bit ALU: combinational datapath plus a one-bit carry latch for 16-bit add sequences.
// Optional DAA support is enabled by defining SM83_ALU_DAA_EN; otherwise op 01100 acts as COPYA.
module sm83_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] alu_op,
  input  logic [3:0] alu_flag_in,
  input  logic [2:0] alu_bit_index,
  input  logic       carry_capture,
  output logic [7:0] alu_out,
  output logic [3:0] alu_flag_out,
  output logic       carry_latched
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00, OP_ADC,  OP_SUB,  OP_SBC,  OP_AND,  OP_XOR,  OP_OR,   OP_CP,
    OP_RLCA  = 5'h08, OP_RRCA, OP_RLA,  OP_RRA,  OP_DAA,  OP_CPL,  OP_SCF,  OP_CCF,
    OP_RLC   = 5'h10, OP_RRC,  OP_RL,   OP_RR,   OP_SLA,  OP_SRA,  OP_SWAP, OP_SRL,
    OP_COPYA = 5'h18, OP_COPYB, OP_INCB, OP_DECB, OP_RSVD, OP_BIT, OP_RES,  OP_SET
  } op_e;

  localparam int unsigned FZ = 3;
  localparam int unsigned FN = 2;
  localparam int unsigned FH = 1;
  localparam int unsigned FC = 0;

  op_e        op;
  logic       cin;
  logic       cin_use;
  logic [8:0] sum9;
  logic [4:0] sum_lo;
  logic [8:0] diff9;
  logic [4:0] diff_lo;
  logic [7:0] bit_mask;
  logic [7:0] res;
  logic [3:0] flg;
  logic       z_upd;
`ifdef SM83_ALU_DAA_EN
  logic [7:0] daa_adj;
  logic       daa_c;
`endif

  assign op       = op_e'(alu_op);
  assign cin      = alu_flag_in[FC];
  // Only ADC/SBC fold the incoming carry into the shared adder/subtractor.
  assign cin_use  = ((op == OP_ADC) || (op == OP_SBC)) && cin;
  assign sum9     = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, cin_use};
  assign sum_lo   = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, cin_use};
  assign diff9    = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, cin_use};
  assign diff_lo  = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'b0, cin_use};
  assign bit_mask = 8'h01 << alu_bit_index;

  always_comb begin
    res   = alu_a;
    flg   = alu_flag_in;
    z_upd = 1'b0;
`ifdef SM83_ALU_DAA_EN
    daa_adj = '0;
    daa_c   = cin;
`endif
    case (op)
      OP_ADD, OP_ADC: begin
        res = sum9[7:0]; z_upd = 1'b1;
        flg[FN] = 1'b0; flg[FH] = sum_lo[4]; flg[FC] = sum9[8];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        res = (op == OP_CP) ? alu_a : diff9[7:0];
        flg[FZ] = (diff9[7:0] == 8'h00);
        flg[FN] = 1'b1; flg[FH] = diff_lo[4]; flg[FC] = diff9[8];
      end
      OP_AND: begin
        res = alu_a & alu_b; z_upd = 1'b1;
        flg[FN] = 1'b0; flg[FH] = 1'b1; flg[FC] = 1'b0;
      end
      OP_XOR, OP_OR: begin
        res = (op == OP_XOR) ? (alu_a ^ alu_b) : (alu_a | alu_b); z_upd = 1'b1;
        flg[FN] = 1'b0; flg[FH] = 1'b0; flg[FC] = 1'b0;
      end
      OP_RLCA: begin res = {alu_a[6:0], alu_a[7]}; flg = {3'b000, alu_a[7]}; end
      OP_RRCA: begin res = {alu_a[0], alu_a[7:1]}; flg = {3'b000, alu_a[0]}; end
      OP_RLA:  begin res = {alu_a[6:0], cin};      flg = {3'b000, alu_a[7]}; end
      OP_RRA:  begin res = {cin, alu_a[7:1]};      flg = {3'b000, alu_a[0]}; end
`ifdef SM83_ALU_DAA_EN
      // Both adjust thresholds look at the original operand, not a partially adjusted one.
      OP_DAA: begin
        if (!alu_flag_in[FN]) begin
          if (cin || (alu_a > 8'h99)) begin
            daa_adj = daa_adj | 8'h60;
            daa_c   = 1'b1;
          end
          if (alu_flag_in[FH] || (alu_a[3:0] > 4'h9)) daa_adj = daa_adj | 8'h06;
          res = alu_a + daa_adj;
        end else begin
          if (cin)             daa_adj = daa_adj | 8'h60;
          if (alu_flag_in[FH]) daa_adj = daa_adj | 8'h06;
          res = alu_a - daa_adj;
        end
        z_upd = 1'b1; flg[FH] = 1'b0; flg[FC] = daa_c;
      end
`endif
      OP_CPL: begin res = ~alu_a; flg[FN] = 1'b1; flg[FH] = 1'b1; end
      OP_SCF: begin flg[FN] = 1'b0; flg[FH] = 1'b0; flg[FC] = 1'b1; end
      OP_CCF: begin flg[FN] = 1'b0; flg[FH] = 1'b0; flg[FC] = ~cin; end
      OP_RLC:  begin res = {alu_a[6:0], alu_a[7]};  flg = {3'b000, alu_a[7]}; z_upd = 1'b1; end
      OP_RRC:  begin res = {alu_a[0], alu_a[7:1]};  flg = {3'b000, alu_a[0]}; z_upd = 1'b1; end
      OP_RL:   begin res = {alu_a[6:0], cin};       flg = {3'b000, alu_a[7]}; z_upd = 1'b1; end
      OP_RR:   begin res = {cin, alu_a[7:1]};       flg = {3'b000, alu_a[0]}; z_upd = 1'b1; end
      OP_SLA:  begin res = {alu_a[6:0], 1'b0};      flg = {3'b000, alu_a[7]}; z_upd = 1'b1; end
      OP_SRA:  begin res = {alu_a[7], alu_a[7:1]};  flg = {3'b000, alu_a[0]}; z_upd = 1'b1; end
      OP_SWAP: begin res = {alu_a[3:0], alu_a[7:4]}; flg = 4'b0000;            z_upd = 1'b1; end
      OP_SRL:  begin res = {1'b0, alu_a[7:1]};      flg = {3'b000, alu_a[0]}; z_upd = 1'b1; end
      OP_COPYB: res = alu_b;
      OP_INCB: begin
        res = alu_b + 8'h01; z_upd = 1'b1;
        flg[FN] = 1'b0; flg[FH] = (alu_b[3:0] == 4'hF);
      end
      OP_DECB: begin
        res = alu_b - 8'h01; z_upd = 1'b1;
        flg[FN] = 1'b1; flg[FH] = (alu_b[3:0] == 4'h0);
      end
      OP_BIT: begin
        flg[FZ] = ~|(alu_a & bit_mask); flg[FN] = 1'b0; flg[FH] = 1'b1;
      end
      OP_RES: res = alu_a & ~bit_mask;
      OP_SET: res = alu_a | bit_mask;
      default: ;  // COPYA, reserved and (when disabled) DAA pass A through with flags unchanged
    endcase
    if (z_upd) flg[FZ] = (res == 8'h00);
  end

  assign alu_out      = res;
  assign alu_flag_out = flg;

  always_ff @(posedge clk) begin
    if (reset)              carry_latched <= 1'b0;
    else if (carry_capture) carry_latched <= alu_flag_out[FC];
  end

endmodule

// File: tb/tb_sm83_alu.sv
// Self-checking bench for sm83_alu: directed vectors plus randomized ops against an integer reference model.
module tb_sm83_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a, alu_b;
  logic [4:0] alu_op;
  logic [3:0] alu_flag_in;
  logic [2:0] alu_bit_index;
  logic       carry_capture;
  logic [7:0] alu_out;
  logic [3:0] alu_flag_out;
  logic       carry_latched;

  int checks = 0;
  int errors = 0;

  sm83_alu dut (
    .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_flag_in(alu_flag_in), .alu_bit_index(alu_bit_index), .carry_capture(carry_capture),
    .alu_out(alu_out), .alu_flag_out(alu_flag_out), .carry_latched(carry_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {out[7:0], flags[3:0]} from plain integer arithmetic.
  function automatic logic [11:0] model(input int op, input int a, input int b,
                                        input logic [3:0] f, input int idx);
    int r, cin, adj;
    logic z, n, h, c, zr;
    cin = int'(f[0]);
    z = f[3]; n = f[2]; h = f[1]; c = f[0];
    r = a; zr = 0;
    case (op)
      0, 1: begin
        if (op == 0) cin = 0;
        r = a + b + cin; zr = 1; n = 0;
        h = (a % 16 + b % 16 + cin) > 15; c = r > 255;
      end
      2, 3, 7: begin
        if (op == 2 || op == 7) cin = 0;
        r = a - b - cin; n = 1;
        h = (a % 16) < (b % 16 + cin); c = a < b + cin;
        z = ((r & 255) == 0);
        if (op == 7) r = a;
      end
      4: begin r = a & b; zr = 1; n = 0; h = 1; c = 0; end
      5: begin r = a ^ b; zr = 1; n = 0; h = 0; c = 0; end
      6: begin r = a | b; zr = 1; n = 0; h = 0; c = 0; end
      8, 16: begin r = (a * 2) % 256 + a / 128;  c = a / 128; end
      9, 17: begin r = a / 2 + (a % 2) * 128;   c = a % 2;   end
      10, 18: begin r = (a * 2) % 256 + cin;    c = a / 128; end
      11, 19: begin r = a / 2 + cin * 128;      c = a % 2;   end
      20: begin r = (a * 2) % 256;              c = a / 128; end
      21: begin r = a / 2 + (a / 128) * 128;    c = a % 2;   end
      22: begin r = (a % 16) * 16 + a / 16;     c = 0;       end
      23: begin r = a / 2;                      c = a % 2;   end
`ifdef SM83_ALU_DAA_EN
      12: begin
        adj = 0;
        if (!f[2]) begin
          if (cin == 1 || a > 153) begin adj += 96; c = 1; end
          if (f[1] || a % 16 > 9) adj += 6;
          r = a + adj;
        end else begin
          if (cin == 1) adj += 96;
          if (f[1]) adj += 6;
          r = a - adj;
        end
        zr = 1; h = 0;
      end
`endif
      13: begin r = 255 - a; n = 1; h = 1; end
      14: begin n = 0; h = 0; c = 1; end
      15: begin n = 0; h = 0; c = ~f[0]; end
      25: r = b;
      26: begin r = b + 1; zr = 1; n = 0; h = (b % 16) == 15; end
      27: begin r = b - 1; zr = 1; n = 1; h = (b % 16) == 0; end
      29: begin z = ((a >> idx) % 2) == 0; n = 0; h = 1; end
      30: r = a - (((a >> idx) % 2) << idx);
      31: r = a | (1 << idx);
      default: ;
    endcase
    if (op >= 8 && op <= 11) begin z = 0; n = 0; h = 0; end
    if (op >= 16 && op <= 23) begin zr = 1; n = 0; h = 0; end
    if (zr) z = ((r & 255) == 0);
    return {8'(r & 255), z, n, h, c};
  endfunction

  task automatic drive(input int op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input int idx);
    alu_op = 5'(op); alu_a = a; alu_b = b; alu_flag_in = f; alu_bit_index = 3'(idx);
    #1;
  endtask

  task automatic directed(input string tag, input int op, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f, input int idx, input logic [7:0] eo, input logic [3:0] ef);
    drive(op, a, b, f, idx);
    check({tag, "_out"}, 32'(alu_out), 32'(eo));
    check({tag, "_flags"}, 32'(alu_flag_out), 32'(ef));
  endtask

  logic [11:0] exp_v;
  logic        exp_latch;

  initial begin
    reset = 1'b1; carry_capture = 1'b0;
    drive(0, 8'h00, 8'h00, 4'h0, 0);
    @(negedge clk); @(negedge clk);
    check("reset_latch", 32'(carry_latched), 32'd0);
    reset = 1'b0;

    directed("add_3a_c6", 0, 8'h3A, 8'hC6, 4'h0, 0, 8'h00, 4'b1011);
    directed("sbc_10_0f", 3, 8'h10, 8'h0F, 4'b0001, 0, 8'h00, 4'b1110);
    directed("sub_3e_3e", 2, 8'h3E, 8'h3E, 4'h0, 0, 8'h00, 4'b1100);
    directed("cp_3e_3e", 7, 8'h3E, 8'h3E, 4'h0, 0, 8'h3E, 4'b1100);
`ifdef SM83_ALU_DAA_EN
    directed("daa_3c", 12, 8'h3C, 8'h00, 4'b0000, 0, 8'h42, 4'b0000);
    directed("daa_9a", 12, 8'h9A, 8'h00, 4'b0000, 0, 8'h00, 4'b1001);
`else
    directed("daa_off", 12, 8'h9A, 8'h00, 4'b0110, 0, 8'h9A, 4'b0110);
`endif
    directed("sra_8a", 21, 8'h8A, 8'h00, 4'hF, 0, 8'hC5, 4'b0000);
    directed("swap_f0", 22, 8'hF0, 8'h00, 4'hF, 0, 8'h0F, 4'b0000);
    directed("bit7_7f", 29, 8'h7F, 8'h00, 4'b0001, 7, 8'h7F, 4'b1011);
    directed("incb_0f", 26, 8'h00, 8'h0F, 4'b0001, 0, 8'h10, 4'b0011);
    directed("incb_ff", 26, 8'h00, 8'hFF, 4'b0000, 0, 8'h00, 4'b1010);
    directed("decb_01", 27, 8'h00, 8'h01, 4'b0001, 0, 8'h00, 4'b1101);
    directed("decb_00", 27, 8'h00, 8'h00, 4'b0000, 0, 8'hFF, 4'b0110);
    directed("rsvd", 28, 8'h55, 8'hAA, 4'b1010, 0, 8'h55, 4'b1010);

    // Carry latch: capture from ADD FF+01, then reset wins over a simultaneous capture.
    drive(0, 8'hFF, 8'h01, 4'h0, 0);
    carry_capture = 1'b1;
    @(negedge clk);
    check("latch_capture", 32'(carry_latched), 32'd1);
    carry_capture = 1'b0; drive(0, 8'h00, 8'h00, 4'h0, 0);
    @(negedge clk);
    check("latch_hold", 32'(carry_latched), 32'd1);
    drive(0, 8'hFF, 8'h01, 4'h0, 0);
    reset = 1'b1; carry_capture = 1'b1;
    @(negedge clk);
    check("latch_reset_prio", 32'(carry_latched), 32'd0);
    reset = 1'b0; carry_capture = 1'b0;
    exp_latch = 1'b0;

    for (int i = 0; i < 400; i++) begin
      int op, idx;
      logic [7:0] a, b;
      logic [3:0] f;
      op = int'($urandom_range(0, 31));
      a = 8'($urandom); b = 8'($urandom); f = 4'($urandom); idx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 7) == 0) b = a;
      @(negedge clk);
      check("rand_latch", 32'(carry_latched), 32'(exp_latch));
      drive(op, a, b, f, idx);
      exp_v = model(op, int'(a), int'(b), f, idx);
      check($sformatf("rand_op%0d_out", op), 32'(alu_out), 32'(exp_v[11:4]));
      check($sformatf("rand_op%0d_flags", op), 32'(alu_flag_out), 32'(exp_v[3:0]));
      reset = ($urandom_range(0, 15) == 0);
      carry_capture = ($urandom_range(0, 1) == 1);
      if (reset) exp_latch = 1'b0;
      else if (carry_capture) exp_latch = exp_v[0];
    end
    @(negedge clk);
    check("rand_latch_final", 32'(carry_latched), 32'(exp_latch));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
